climate_predictor_mc: RTL and testbench
=======================================

Name: climate_predictor_mc

Overview:
Parametrised multi-channel successor to the single-stream climate_prediction block. It accepts channel-tagged sensor samples over a valid/ready stream and keeps a per-channel sliding-window moving average. It derives a per-channel trend and emits a combined weather prediction over a valid/ready output stream. It sits between the sensor front-end and the reporting logic and is driven by the system clock clk.

Parameters:
NUM_CH, 3, sensor channel count (>=3); ch0 temperature, ch1 humidity, ch2 pressure, ch3+ auxiliary (averaged/trended only)
DATA_W, 12, unsigned sample width
WIN, 4, moving-average window depth; power of 2, >=2
TREND_TOL, 2, dead-band in LSBs for trend classification
CH_W, $clog2(NUM_CH) min 1, channel tag width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample
in_ch  in  CH_W  channel tag
in_data  in  DATA_W  sample value
cfg_hum_thresh  in  DATA_W  humidity average threshold; quasi-static
out_valid  out  1  prediction valid
out_ready  in  1  consumer accepts prediction
out_pred  out  2  0 SUNNY, 1 CLOUDY, 2 RAINY, 3 STORM
out_avg  out  NUM_CH*DATA_W  per-channel averages, ch0 in LSBs
out_trend  out  NUM_CH*2  per-channel trend: 0 STEADY, 1 RISING, 2 FALLING
err_ch  out  1  sticky flag: a sample arrived with in_ch >= NUM_CH

Behaviour:
- Clock is clk. Reset is asynchronous and active-high, named reset.
- Reset values: in_ready=1, out_valid=0, out_pred=0, out_avg=0, out_trend=0, err_ch=0. All window buffers, sums, fill counters, round bitmap and previous averages are cleared.
- A sample transfers when in_valid & in_ready.
- Per-channel circular buffer of WIN entries plus a running sum of width DATA_W+log2(WIN).
  - On accept: sum <= sum + in_data - oldest; the new sample overwrites the oldest entry; write pointer wraps modulo WIN.
  - The fill counter saturates at WIN.
- Invalid tag (in_ch >= NUM_CH): sample is accepted and discarded, err_ch is set. err_ch clears only on reset.
- Round bitmap: the accepted channel's bit is set. A duplicate sample in the same round is still accepted and updates the window; the bit stays set.
- FSM states: ACCUM, COMPUTE, EMIT.
  - ACCUM: in_ready=1. Move to COMPUTE on the cycle after the bitmap becomes all-ones AND every fill counter equals WIN (warm-up complete).
  - COMPUTE: in_ready=0, one cycle.
    - avg[c] = sum[c] >> log2(WIN), truncating.
    - diff = avg - prev_avg, signed. Trend is RISING if diff > TREND_TOL, FALLING if diff < -TREND_TOL, else STEADY.
    - The first emission after reset reports all channels STEADY.
    - The prediction is registered. Go to EMIT.
  - EMIT: out_valid=1, in_ready=0. out_* stay stable until out_ready.
    - On handshake: out_valid=0, prev_avg <= avg, bitmap cleared, go to ACCUM.
- Prediction priority (H = avg[1] >= cfg_hum_thresh, P = trend[2]==FALLING): STORM if H&P; RAINY if H; CLOUDY if P; else SUNNY.
- Latency: 2 cycles from the accept of the round-completing sample to out_valid=1.
- Backpressure: if out_ready is held low, the block stalls indefinitely and no input is lost (in_ready=0).
- Reset mid-operation: immediate return to ACCUM with all state cleared. Warm-up restarts and the next emission again reports STEADY.
- cfg_hum_thresh is sampled only in COMPUTE.

Decomposition:
- Package climate_pkg holds:
  - pred_e enum (SUNNY, CLOUDY, RAINY, STORM)
  - trend_e enum (STEADY, RISING, FALLING)
  - fsm state enum
  - channel-index constants CH_TEMP=0, CH_HUM=1, CH_PRESS=2
- One sub-module climate_mavg_ch: a single channel's circular buffer, running sum, fill counter and avg output. It is instantiated NUM_CH times in a generate loop.

Test Plan:
1. Warm-up gating: 3 rounds of ch0..2 = 100 each. Required: no out_valid. 4th round -> out_valid 2 cycles after the last accept, avg=100/100/100, trends STEADY, cfg_hum_thresh=200 -> SUNNY.
2. Storm: after warm-up, pressure steps 1000 -> 900 over 4 rounds and humidity is 250 with cfg_hum_thresh=200. Required: trend[2]=FALLING, out_pred=STORM. With humidity=150 -> CLOUDY.
3. Dead-band: avg changes by +2 -> STEADY; by +3 -> RISING; by -3 -> FALLING.
4. Backpressure: hold out_ready=0 for 10 cycles in EMIT. Required: in_ready=0, outputs stable throughout, handshake on release, and no sample dropped when driven again.
5. Invalid/duplicate tags: in_ch=3 with NUM_CH=3 sets err_ch=1 and leaves averages unchanged. A duplicate ch0 within a round updates the window but does not complete the round.
6. Async reset asserted in EMIT mid-cycle: out_valid drops immediately and in_ready=1. After reset, 3 rounds produce no output; the 4th round emits with all trends STEADY.

Source files
------------

// File: rtl/climate_pkg.sv
// Shared types and constants for the multi-channel climate predictor.
//   pred_e  : combined weather prediction code
//   trend_e : per-channel trend classification
//   state_e : control FSM states
//   CH_*    : fixed channel roles (temperature, humidity, pressure)
package climate_pkg;

  typedef enum logic [1:0] {
    PRED_SUNNY  = 2'd0,
    PRED_CLOUDY = 2'd1,
    PRED_RAINY  = 2'd2,
    PRED_STORM  = 2'd3
  } pred_e;

  typedef enum logic [1:0] {
    TR_STEADY  = 2'd0,
    TR_RISING  = 2'd1,
    TR_FALLING = 2'd2
  } trend_e;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  localparam int unsigned CH_TEMP  = 0;
  localparam int unsigned CH_HUM   = 1;
  localparam int unsigned CH_PRESS = 2;

  // Humidity-high dominates; a falling pressure upgrades rain to storm.
  function automatic pred_e predict(input logic i_hum_hi, input logic i_press_fall);
    if (i_hum_hi && i_press_fall) return PRED_STORM;
    if (i_hum_hi)                 return PRED_RAINY;
    if (i_press_fall)             return PRED_CLOUDY;
    return PRED_SUNNY;
  endfunction

endpackage

// File: rtl/climate_mavg_ch.sv
// One channel's sliding-window moving average.
//   clk, rst : clock, asynchronous active-high reset
//   i_we     : write one sample into the window
//   i_data   : sample value
//   o_avg    : window sum divided by WIN (truncating)
//   o_full   : WIN samples have been written since reset
module climate_mavg_ch #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned WIN    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_avg,
  output logic              o_full
);

  localparam int unsigned LW     = $clog2(WIN);
  localparam int unsigned SUM_W  = DATA_W + LW;
  localparam int unsigned FILL_W = $clog2(WIN + 1);

  logic [DATA_W-1:0] r_buf [WIN];
  logic [LW-1:0]     r_wptr;
  logic [SUM_W-1:0]  r_sum;
  logic [FILL_W-1:0] r_fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIN; i++) r_buf[i] <= '0;
      r_wptr <= '0;
      r_sum  <= '0;
      r_fill <= '0;
    end else if (i_we) begin
      // Buffer starts zeroed, so the running sum always equals the
      // buffer contents and the subtraction never underflows overall.
      r_buf[r_wptr] <= i_data;
      r_wptr        <= r_wptr + 1'b1;
      r_sum         <= r_sum + SUM_W'(i_data) - SUM_W'(r_buf[r_wptr]);
      if (r_fill != FILL_W'(WIN)) r_fill <= r_fill + 1'b1;
    end
  end

  assign o_avg  = DATA_W'(r_sum >> LW);
  assign o_full = (r_fill == FILL_W'(WIN));

endmodule

// File: rtl/climate_predictor_mc.sv
// Multi-channel climate predictor: per-channel moving averages and trends,
// combined into one weather prediction per completed sample round.
//   clk, reset       : clock, asynchronous active-high reset
//   in_valid/ready   : channel-tagged sample stream (in_ch, in_data)
//   cfg_hum_thresh   : humidity average threshold, sampled in COMPUTE
//   out_valid/ready  : prediction stream (out_pred, out_avg, out_trend)
//   err_ch           : sticky, set by a sample with an out-of-range tag
module climate_predictor_mc
  import climate_pkg::*;
#(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned WIN       = 4,
  parameter int unsigned TREND_TOL = 2,
  parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [DATA_W-1:0]        cfg_hum_thresh,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_pred,
  output logic [NUM_CH*DATA_W-1:0] out_avg,
  output logic [NUM_CH*2-1:0]      out_trend,
  output logic                     err_ch
);

  localparam logic signed [DATA_W:0] TOL_S = (DATA_W+1)'(TREND_TOL);

  state_e                   r_state, w_next;
  logic [NUM_CH-1:0]        r_seen;
  logic                     r_first;
  logic                     r_err;
  logic [DATA_W-1:0]        r_prev [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] r_avg;
  logic [NUM_CH*2-1:0]      r_trend;
  pred_e                    r_pred;

  logic                     w_accept;
  logic                     w_ch_ok;
  logic                     w_round_done;
  logic [NUM_CH-1:0]        w_full;
  logic [DATA_W-1:0]        w_avg   [NUM_CH];
  logic signed [DATA_W:0]   w_diff  [NUM_CH];
  trend_e                   w_trend [NUM_CH];
  logic                     w_hum_hi;
  logic                     w_press_fall;
  pred_e                    w_pred;

  assign w_ch_ok      = (32'(in_ch) < NUM_CH);
  assign w_accept     = in_valid & in_ready;
  assign w_round_done = (&r_seen) & (&w_full);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    climate_mavg_ch #(
      .DATA_W (DATA_W),
      .WIN    (WIN)
    ) u_mavg (
      .clk    (clk),
      .rst    (reset),
      .i_we   (w_accept && w_ch_ok && (in_ch == CH_W'(g))),
      .i_data (in_data),
      .o_avg  (w_avg[g]),
      .o_full (w_full[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_ACCUM;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (w_round_done) w_next = ST_COMPUTE;
      end
      ST_COMPUTE: w_next = ST_EMIT;
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_ACCUM;
      end
      default: w_next = ST_ACCUM;
    endcase
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_diff[c]  = $signed({1'b0, w_avg[c]}) - $signed({1'b0, r_prev[c]});
      w_trend[c] = TR_STEADY;
      if (!r_first) begin
        if (w_diff[c] > TOL_S)       w_trend[c] = TR_RISING;
        else if (w_diff[c] < -TOL_S) w_trend[c] = TR_FALLING;
      end
    end
  end

  assign w_hum_hi     = (w_avg[CH_HUM] >= cfg_hum_thresh);
  assign w_press_fall = (w_trend[CH_PRESS] == TR_FALLING);
  assign w_pred       = predict(w_hum_hi, w_press_fall);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seen  <= '0;
      r_first <= 1'b1;
      r_err   <= 1'b0;
      r_avg   <= '0;
      r_trend <= '0;
      r_pred  <= PRED_SUNNY;
      for (int unsigned c = 0; c < NUM_CH; c++) r_prev[c] <= '0;
    end else begin
      if (w_accept) begin
        if (w_ch_ok) r_seen[in_ch] <= 1'b1;
        else         r_err         <= 1'b1;
      end
      if (r_state == ST_COMPUTE) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          r_avg[c*DATA_W +: DATA_W] <= w_avg[c];
          r_trend[c*2 +: 2]         <= w_trend[c];
        end
        r_pred <= w_pred;
      end
      if ((r_state == ST_EMIT) && out_ready) begin
        r_seen  <= '0;
        r_first <= 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) r_prev[c] <= r_avg[c*DATA_W +: DATA_W];
      end
    end
  end

  assign out_avg   = r_avg;
  assign out_trend = r_trend;
  assign out_pred  = r_pred;
  assign err_ch    = r_err;

endmodule

// File: tb/tb_climate_predictor_mc.sv
module tb_climate_predictor_mc;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 12;
  localparam int WIN    = 4;
  localparam int TOL    = 2;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic [DATA_W-1:0]        in_data;
  logic [DATA_W-1:0]        cfg_hum_thresh;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               out_pred;
  logic [NUM_CH*DATA_W-1:0] out_avg;
  logic [NUM_CH*2-1:0]      out_trend;
  logic                     err_ch;

  climate_predictor_mc #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .WIN       (WIN),
    .TREND_TOL (TOL),
    .CH_W      (CH_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ch          (in_ch),
    .in_data        (in_data),
    .cfg_hum_thresh (cfg_hum_thresh),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pred       (out_pred),
    .out_avg        (out_avg),
    .out_trend      (out_trend),
    .err_ch         (err_ch)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: last WIN samples per channel kept as plain queues.
  int  q [NUM_CH][$];
  bit  m_seen [NUM_CH];
  int  phase;            // 0 collecting, 1 computing, 2 presenting
  bit  m_first;
  bit  m_err;
  int  m_prev [NUM_CH];
  int  m_avg  [NUM_CH];
  int  m_tr   [NUM_CH];
  int  m_pred;

  function automatic int win_avg(int c);
    int s = 0;
    for (int i = 0; i < q[c].size(); i++) s += q[c][i];
    return s / WIN;
  endfunction

  task automatic m_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      q[c].delete();
      m_seen[c] = 0;
      m_prev[c] = 0;
      m_avg[c]  = 0;
      m_tr[c]   = 0;
    end
    phase = 0; m_first = 1; m_err = 0; m_pred = 0;
  endtask

  task automatic m_step();
    bit done;
    int ch, d;
    bit h, p;
    case (phase)
      0: begin
        done = 1;
        for (int c = 0; c < NUM_CH; c++)
          if (!m_seen[c] || q[c].size() != WIN) done = 0;
        if (in_valid) begin
          ch = int'(in_ch);
          if (ch < NUM_CH) begin
            q[ch].push_back(int'(in_data));
            if (q[ch].size() > WIN) void'(q[ch].pop_front());
            m_seen[ch] = 1;
          end else m_err = 1;
        end
        if (done) phase = 1;
      end
      1: begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_avg[c] = win_avg(c);
          d = m_avg[c] - m_prev[c];
          m_tr[c] = m_first ? 0 : (d > TOL) ? 1 : (d < -TOL) ? 2 : 0;
        end
        h = m_avg[1] >= int'(cfg_hum_thresh);
        p = m_tr[2] == 2;
        m_pred = (h && p) ? 3 : h ? 2 : p ? 1 : 0;
        phase = 2;
      end
      default: begin
        if (out_ready) begin
          for (int c = 0; c < NUM_CH; c++) begin
            m_prev[c] = m_avg[c];
            m_seen[c] = 0;
          end
          m_first = 0;
          phase = 0;
        end
      end
    endcase
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_clear();
      else       m_step();
    end
  end

  // Hand-computed expectations posted by the stimulus process.
  typedef struct {
    string  name;
    longint act;
    longint exp;
  } lit_t;
  lit_t litq[$];

  task automatic lit(input string n, input longint a, input longint e);
    litq.push_back('{n, a, e});
  endtask

  task automatic check(input string n, input longint a, input longint e);
    n_vec++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
    end
  endtask

  initial forever begin
    lit_t l;
    @(negedge clk);
    while (litq.size() > 0) begin
      l = litq.pop_front();
      check(l.name, l.act, l.exp);
    end
    if (!reset) begin
      check("in_ready",  longint'(in_ready),  longint'(phase == 0));
      check("out_valid", longint'(out_valid), longint'(phase == 2));
      check("err_ch",    longint'(err_ch),    longint'(m_err));
      if (phase == 2) begin
        for (int c = 0; c < NUM_CH; c++) begin
          check($sformatf("avg%0d", c),   longint'(out_avg[c*DATA_W +: DATA_W]), m_avg[c]);
          check($sformatf("trend%0d", c), longint'(out_trend[c*2 +: 2]),         m_tr[c]);
        end
        check("pred", longint'(out_pred), m_pred);
      end
    end
  end

  function automatic int avg_of(int c);
    return int'(out_avg[c*DATA_W +: DATA_W]);
  endfunction

  function automatic int tr_of(int c);
    return int'(out_trend[c*2 +: 2]);
  endfunction

  task automatic send(input int ch, input int d);
    int t = 0;
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    in_data  = DATA_W'(d);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) lit("in_ready_wait", longint'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic round(input int a, input int b, input int c);
    send(0, a);
    send(1, b);
    send(2, c);
  endtask

  task automatic wait_emit(output int t);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    lit("emit_seen", longint'(out_valid), 1);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int base [NUM_CH];
    int ch;

    reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0;
    out_ready = 1'b0; cfg_hum_thresh = 12'd200;
    repeat (3) @(negedge clk);
    lit("rst_in_ready",  longint'(in_ready),  1);
    lit("rst_out_valid", longint'(out_valid), 0);
    lit("rst_pred",      longint'(out_pred),  0);
    lit("rst_avg",       longint'(out_avg),   0);
    lit("rst_trend",     longint'(out_trend), 0);
    lit("rst_err",       longint'(err_ch),    0);
    reset = 1'b0;
    @(negedge clk);

    // Warm-up: only the fourth round of 100s may emit.
    for (int r = 0; r < 3; r++) round(100, 100, 100);
    repeat (3) @(negedge clk);
    lit("warm_no_emit", longint'(out_valid), 0);
    round(100, 100, 100);
    wait_emit(t);
    lit("warm_latency", t, 2);
    for (int c = 0; c < NUM_CH; c++) lit($sformatf("warm_avg%0d", c), avg_of(c), 100);
    lit("warm_trend", longint'(out_trend), 0);
    lit("warm_pred",  longint'(out_pred),  0);
    ack();

    // Pressure 1000 then stepping to 900 with humid air.
    for (int r = 0; r < 4; r++) begin round(100, 250, 1000); wait_emit(t); ack(); end
    for (int r = 0; r < 4; r++) begin
      round(100, 250, 900);
      wait_emit(t);
      if (r == 0) lit("storm_avg2_r0", avg_of(2), 975);
      if (r == 3) begin
        lit("storm_avg1",   avg_of(1), 250);
        lit("storm_avg2",   avg_of(2), 900);
        lit("storm_trend2", tr_of(2),  2);
        lit("storm_pred",   longint'(out_pred), 3);
      end
      ack();
    end

    // Humidity drops while pressure keeps falling: 225,200 (boundary),175,150.
    for (int r = 0; r < 4; r++) begin
      round(100, 150, 800);
      wait_emit(t);
      if (r == 1) begin
        lit("hum_edge_avg1", avg_of(1), 200);
        lit("hum_edge_pred", longint'(out_pred), 3);
      end
      if (r == 3) begin
        lit("cloudy_avg1", avg_of(1), 150);
        lit("cloudy_pred", longint'(out_pred), 1);
      end
      ack();
    end

    // Dead-band on ch0: +2 steady, +3 rising, -3 falling.
    round(108, 150, 800); wait_emit(t);
    lit("db_avg_p2", avg_of(0), 102); lit("db_tr_p2", tr_of(0), 0); ack();
    round(112, 150, 800); wait_emit(t);
    lit("db_avg_p3", avg_of(0), 105); lit("db_tr_p3", tr_of(0), 1); ack();
    round(88, 150, 800); wait_emit(t);
    lit("db_avg_m3", avg_of(0), 102); lit("db_tr_m3", tr_of(0), 2); ack();

    // Backpressure with a sample waiting at the input.
    round(100, 150, 800);
    wait_emit(t);
    in_valid = 1'b1; in_ch = 2'd0; in_data = 12'd500;
    repeat (10) begin
      @(negedge clk);
      lit("bp_in_ready",  longint'(in_ready),  0);
      lit("bp_out_valid", longint'(out_valid), 1);
      lit("bp_avg0",      avg_of(0),           102);
    end
    ack();
    lit("bp_ready_after", longint'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    send(1, 150); send(2, 800);
    wait_emit(t);
    lit("bp_avg0_kept", avg_of(0), 200);
    lit("bp_tr0",       tr_of(0),  1);
    ack();

    // Invalid tag, then a duplicate ch0 inside one round.
    send(3, 4000);
    lit("inv_err", longint'(err_ch), 1);
    send(0, 200); send(0, 200); send(1, 150);
    repeat (4) @(negedge clk);
    lit("dup_no_emit", longint'(out_valid), 0);
    send(2, 800);
    wait_emit(t);
    lit("dup_avg0", avg_of(0), 250);
    lit("dup_avg1", avg_of(1), 150);
    ack();

    // Asynchronous reset while presenting a result.
    round(100, 150, 800);
    wait_emit(t);
    #2 reset = 1'b1;
    #1;
    lit("arst_out_valid", longint'(out_valid), 0);
    lit("arst_in_ready",  longint'(in_ready),  1);
    lit("arst_err",       longint'(err_ch),    0);
    lit("arst_avg",       longint'(out_avg),   0);
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 3; r++) round(300, 300, 300);
    repeat (3) @(negedge clk);
    lit("arst_no_emit", longint'(out_valid), 0);
    round(300, 300, 300);
    wait_emit(t);
    lit("arst_trend", longint'(out_trend), 0);
    lit("arst_avg0",  avg_of(0), 300);
    ack();

    // Randomized traffic against the model.
    for (int c = 0; c < NUM_CH; c++) base[c] = $urandom_range(100, 3900);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = 1'b0;
      if ($urandom_range(0, 799) == 0) begin
        #2 reset = 1'b1;
        continue;
      end
      in_valid = ($urandom_range(0, 9) < 7);
      ch = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      in_ch = CH_W'(ch);
      if ($urandom_range(0, 3) == 0) in_data = DATA_W'($urandom_range(0, 4095));
      else                           in_data = DATA_W'(base[ch % NUM_CH] + int'($urandom_range(0, 6)));
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) cfg_hum_thresh = DATA_W'($urandom_range(0, 4095));
      if ($urandom_range(0, 49) == 0) base[$urandom_range(0, 2)] = $urandom_range(100, 3900);
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
